cam_lookup_unit: RTL and testbench
==================================

CAM_LOOKUP_UNIT -- requirements
Module: cam_lookup_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each stored entry and of the search key.
REQ-002 SHALL have fixed depth of 4 entries, indexed 0-3 by a 2-bit index matching the downstream 4:1 selector width; depth is not a parameter.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 SHALL have these ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- write_en  input  1  load write_data into entry write_index and set its valid bit.
- write_index  input  2  target entry for a write.
- write_data  input  WIDTH  data to store.
- invalidate_en  input  1  clear valid bit of entry invalidate_index.
- invalidate_index  input  2  target entry for an invalidate.
- search_en  input  1  start a search with search_data.
- search_data  input  WIDTH  search key.
- search_valid  output  1  one-cycle pulse; search result fields are valid.
- search_hit  output  1  at least one valid entry matched.
- search_index  output  2  lowest matching index; drives the downstream 4:1 selector bits.
- search_multi  output  1  two or more valid entries matched.
- full  output  1  all 4 entries valid.
- empty  output  1  no entries valid.
- valid_count  output  3  number of valid entries, 0-4.

Function
REQ-005 SHALL match entry i when valid[i]=1 and data[i]==search_data, using an exact compare over all WIDTH bits.
REQ-006 SHALL use a 2-stage search pipeline:
- Stage 1 registers the 4-bit match vector and a stage valid flag on the edge that samples search_en.
- Stage 2 registers the priority-encoded result on the next edge.
REQ-007 SHALL assert search_valid for exactly one cycle, 2 cycles after search_en is sampled (search_en high before edge N, result visible after edge N+1).
REQ-008 SHALL accept a search on every cycle with no stall; N back-to-back searches SHALL yield N consecutive search_valid pulses in issue order.
REQ-009 SHALL set search_index to the lowest matching index, and to 0 when search_hit=0.
REQ-010 SHALL set search_hit=0 and search_multi=0 on a miss, and SHALL still pulse search_valid for that search.
REQ-011 SHALL hold search_hit, search_index and search_multi at their last values while search_valid=0.
REQ-012 SHALL make a write visible at the clock edge that samples it; a search sampled on the same edge SHALL compare against the pre-write contents.
REQ-013 SHALL make an invalidate take effect at its sampling edge; a same-edge search SHALL see the entry as still valid.
REQ-014 SHALL give write priority when write_en and invalidate_en target the same index in the same cycle: entry ends valid with write_data.
REQ-015 SHALL apply write and invalidate independently when they target different indices in the same cycle.
REQ-016 SHALL, when writing an already-valid entry, overwrite its data and leave it valid with valid_count unchanged.
REQ-017 SHALL, when invalidating an already-invalid entry, make no change.
REQ-018 SHALL keep a stage-1 match vector for an in-flight search unaffected by later writes or invalidates.
REQ-019 SHALL register valid_count, full and empty, updated on the same edge as the valid bits, so they reflect the new state in the following cycle.
REQ-020 SHALL guarantee full=1 iff valid_count==4, and empty=1 iff valid_count==0.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, clear all valid bits, clear all entry data to 0, and clear both pipeline stage valid flags.
REQ-022 SHALL drive these values after reset: search_valid=0, search_hit=0, search_index=0, search_multi=0, full=0, empty=1, valid_count=0.
REQ-023 SHALL drop in-flight searches when reset is asserted mid-operation: no search_valid pulse is produced for searches sampled before or during reset.
REQ-024 SHALL give reset priority over write_en, invalidate_en and search_en in the same cycle.

Verification
REQ-025 SHALL cover write followed by search (WIDTH=32):
- Stimulus: write 0xA5A5_0001 to index 2, then search 0xA5A5_0001 the next cycle.
- Response: search_valid 2 cycles later with hit=1, index=2, multi=0, valid_count=1.
REQ-026 SHALL cover duplicate entries:
- Stimulus: write 0x55 to indices 1 and 3, then search 0x55.
- Response: hit=1, index=1, multi=1.
REQ-027 SHALL cover same-cycle write and search:
- Stimulus: write 0x77 to index 0 in the same cycle as a search for 0x77 on an empty CAM.
- Response: hit=0; a repeat search the next cycle gives hit=1, index=0.
REQ-028 SHALL cover fill and drain:
- Stimulus: fill all 4 entries, then invalidate index 0 while writing index 0 in the same cycle, then invalidate all 4 entries.
- Response: full=1 after the fill; count stays 4 after the combined write/invalidate; empty=1 and count=0 after draining.
REQ-029 SHALL cover reset mid-pipeline:
- Stimulus: issue 3 back-to-back searches and assert reset in the cycle after the first.
- Response: no search_valid pulses appear; all outputs are at reset values.

Source files
------------

// File: rtl/cam_lookup_unit_if.sv
// Bus bundle for the 4-entry CAM: write, invalidate and search requests plus
// the search result and occupancy status.
interface cam_lookup_unit_if #(
    parameter int WIDTH = 32
);
    logic             write_en;
    logic [1:0]       write_index;
    logic [WIDTH-1:0] write_data;
    logic             invalidate_en;
    logic [1:0]       invalidate_index;
    logic             search_en;
    logic [WIDTH-1:0] search_data;
    logic             search_valid;
    logic             search_hit;
    logic [1:0]       search_index;
    logic             search_multi;
    logic             full;
    logic             empty;
    logic [2:0]       valid_count;

    modport master (
        output write_en, write_index, write_data,
        output invalidate_en, invalidate_index,
        output search_en, search_data,
        input  search_valid, search_hit, search_index, search_multi,
        input  full, empty, valid_count
    );

    modport slave (
        input  write_en, write_index, write_data,
        input  invalidate_en, invalidate_index,
        input  search_en, search_data,
        output search_valid, search_hit, search_index, search_multi,
        output full, empty, valid_count
    );
endinterface

// File: rtl/cam_lookup_unit.sv
// Four-entry content-addressable lookup with a two-stage search pipeline
// (match vector, then priority encode) and registered occupancy status.
module cam_lookup_unit #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    cam_lookup_unit_if.slave bus
);
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [2:0]       count_q, count_d;
    logic             full_q, empty_q;

    logic [3:0]       match_d;
    logic [3:0]       s1_match_q, s1_match_d;
    logic             s1_valid_q;

    logic             sv_q;
    logic             hit_q, hit_d;
    logic [1:0]       idx_q, idx_d;
    logic             multi_q, multi_d;

    // Storage update: invalidate first so a same-index write wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (bus.invalidate_en) begin
            valid_d[bus.invalidate_index] = 1'b0;
        end
        if (bus.write_en) begin
            valid_d[bus.write_index] = 1'b1;
            data_d[bus.write_index]  = bus.write_data;
        end
        count_d = 3'(valid_d[0]) + 3'(valid_d[1]) + 3'(valid_d[2]) + 3'(valid_d[3]);
    end

    // Compare against pre-write contents; the match vector is frozen once captured.
    always_comb begin
        match_d = '0;
        for (int i = 0; i < 4; i++) begin
            match_d[i] = valid_q[i] && (data_q[i] == bus.search_data);
        end
        s1_match_d = bus.search_en ? match_d : s1_match_q;
    end

    // Stage 2 priority encode; result fields hold when no search is completing.
    always_comb begin
        hit_d   = hit_q;
        idx_d   = idx_q;
        multi_d = multi_q;
        if (s1_valid_q) begin
            hit_d   = |s1_match_q;
            multi_d = (s1_match_q & (s1_match_q - 4'd1)) != 4'd0;
            idx_d   = 2'd0;
            for (int i = 3; i >= 0; i--) begin
                if (s1_match_q[i]) begin
                    idx_d = 2'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: entry data is cleared on reset here because the reset state of the contents is observable behaviour, not just the valid bits.
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            valid_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            s1_match_q <= '0;
            s1_valid_q <= 1'b0;
            sv_q       <= 1'b0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            multi_q    <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            full_q     <= (valid_d == 4'hF);
            empty_q    <= (valid_d == 4'h0);
            s1_match_q <= s1_match_d;
            s1_valid_q <= bus.search_en;
            sv_q       <= s1_valid_q;
            hit_q      <= hit_d;
            idx_q      <= idx_d;
            multi_q    <= multi_d;
        end
    end

    assign bus.search_valid = sv_q;
    assign bus.search_hit   = hit_q;
    assign bus.search_index = idx_q;
    assign bus.search_multi = multi_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.valid_count  = count_q;
endmodule

// File: tb/tb_cam_lookup_unit.sv
// Scoreboard bench for cam_lookup_unit: directed scenarios plus random traffic
// checked against an array-based model of the CAM contents.
module tb_cam_lookup_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cam_lookup_unit_if #(.WIDTH(WIDTH)) bus ();
    cam_lookup_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       hit;
        logic [1:0] idx;
        logic       multi;
        int         due;
    } exp_t;

    exp_t             sb [$];
    logic [WIDTH-1:0] m_data [4];
    bit               m_valid [4];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    bit               started = 1'b0;
    logic             last_hit;
    logic [1:0]       last_idx;
    logic             last_multi;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 4; i++) c += m_valid[i] ? 1 : 0;
        return c;
    endfunction

    // One clock edge: record what the DUT sampled into the model and scoreboard.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_valid[i] = 1'b0;
                m_data[i]  = '0;
            end
            sb.delete();
            last_hit   = 1'b0;
            last_idx   = 2'd0;
            last_multi = 1'b0;
            started    = 1'b1;
        end else begin
            if (bus.search_en) begin
                exp_t e;
                int   hits;
                hits  = 0;
                e.idx = 2'd0;
                for (int i = 3; i >= 0; i--) begin
                    if (m_valid[i] && m_data[i] == bus.search_data) begin
                        hits++;
                        e.idx = 2'(i);
                    end
                end
                e.hit   = (hits > 0);
                e.multi = (hits > 1);
                e.due   = cyc + 1;
                sb.push_back(e);
            end
            if (bus.invalidate_en) m_valid[bus.invalidate_index] = 1'b0;
            if (bus.write_en) begin
                m_valid[bus.write_index] = 1'b1;
                m_data[bus.write_index]  = bus.write_data;
            end
        end
        #1;
    endtask

    task automatic drive(bit we, bit [1:0] wi, logic [WIDTH-1:0] wd,
                         bit ie, bit [1:0] ii,
                         bit se, logic [WIDTH-1:0] sd, bit rst);
        reset                = rst;
        bus.write_en         = we;
        bus.write_index      = wi;
        bus.write_data       = wd;
        bus.invalidate_en    = ie;
        bus.invalidate_index = ii;
        bus.search_en        = se;
        bus.search_data      = sd;
        tick();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, '0, 0, 0, 0, '0, 1);
    endtask

    task automatic write(bit [1:0] wi, logic [WIDTH-1:0] wd);
        drive(1, wi, wd, 0, 0, 0, '0, 0);
    endtask

    task automatic search(logic [WIDTH-1:0] sd);
        drive(0, 0, '0, 0, 0, 1, sd, 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_search_valid"}, bus.search_valid, 0);
        check({tag, "_search_hit"},   bus.search_hit,   0);
        check({tag, "_search_index"}, bus.search_index, 0);
        check({tag, "_search_multi"}, bus.search_multi, 0);
        check({tag, "_full"},         bus.full,         0);
        check({tag, "_empty"},        bus.empty,        1);
        check({tag, "_valid_count"},  bus.valid_count,  0);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        if ($urandom_range(0, 7) == 0) return WIDTH'($urandom);
        return WIDTH'(32'hC0DE_0000 | $urandom_range(0, 3));
    endfunction

    // Monitor: status every cycle, result fields against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("valid_count", bus.valid_count, model_count());
                check("full",  bus.full,  model_count() == 4);
                check("empty", bus.empty, model_count() == 0);
                if (bus.search_valid) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: search_valid=1 with no search pending (cycle %0d)", cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("latency",      cyc,              e.due);
                        check("search_hit",   bus.search_hit,   e.hit);
                        check("search_index", bus.search_index, e.idx);
                        check("search_multi", bus.search_multi, e.multi);
                        last_hit   = e.hit;
                        last_idx   = e.idx;
                        last_multi = e.multi;
                    end
                end else begin
                    check("hold_hit",   bus.search_hit,   last_hit);
                    check("hold_index", bus.search_index, last_idx);
                    check("hold_multi", bus.search_multi, last_multi);
                    if (sb.size() > 0 && sb[0].due <= cyc) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL missing_pulse: search_valid=0 expected 1 (cycle %0d)", cyc);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        do_reset();
        check_reset_outputs("reset");

        // Write then search the next cycle.
        write(2'd2, 32'hA5A5_0001);
        search(32'hA5A5_0001);
        check("wr_search_count", bus.valid_count, 1);
        idle(3);

        // Duplicate entries: lowest index wins, multi flagged.
        do_reset();
        write(2'd1, 32'h55);
        write(2'd3, 32'h55);
        search(32'h55);
        idle(3);

        // Same-edge write and search sees the old contents.
        do_reset();
        drive(1, 2'd0, 32'h77, 0, 0, 1, 32'h77, 0);
        search(32'h77);
        idle(3);

        // Fill, combined write/invalidate on one index, drain.
        do_reset();
        for (int i = 0; i < 4; i++) write(2'(i), 32'h1000 + i);
        check("fill_full",  bus.full,        1);
        check("fill_count", bus.valid_count, 4);
        drive(1, 2'd0, 32'h2000, 1, 2'd0, 0, '0, 0);
        check("wr_inv_count", bus.valid_count, 4);
        search(32'h2000);
        drive(1, 2'd1, 32'h1001, 0, 0, 0, '0, 0);
        check("overwrite_count", bus.valid_count, 4);
        for (int i = 0; i < 4; i++) drive(0, 0, '0, 1, 2'(i), 0, '0, 0);
        check("drain_empty", bus.empty,       1);
        check("drain_count", bus.valid_count, 0);
        drive(0, 0, '0, 1, 2'd0, 0, '0, 0);
        check("inv_empty_count", bus.valid_count, 0);
        idle(2);

        // Reset while searches are in flight: no pulses may emerge.
        do_reset();
        write(2'd0, 32'h9);
        search(32'h9);
        drive(0, 0, '0, 0, 0, 1, 32'h9, 1);
        drive(0, 0, '0, 0, 0, 1, 32'h9, 1);
        idle(3);
        check_reset_outputs("mid_reset");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), pick(),
                  $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, pick(),
                  $urandom_range(0, 63) == 0);
        end
        idle(4);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
